// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 Set-2 prefix resolver with FWFT key-event FIFO
// Optional make-repeat suppression when TYPEMATIC_FILTER_EN is defined.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_listo,
    input  logic [7:0] codigo_tecla,
    output logic       rx_enable,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          held_v_q, held_v_d;
    logic [8:0]    held_q, held_d;

    logic       is_junk, is_e0, is_f0;
    logic       push_req, push_ok, pop, wr_en;
    logic       push_brk, push_ext;
    logic [9:0] head;

    always_comb begin
        is_e0 = (codigo_tecla == 8'hE0);
        is_f0 = (codigo_tecla == 8'hF0);
        case (codigo_tecla)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_junk = 1'b1;
            default:                                          is_junk = 1'b0;
        endcase

        state_d  = state_q;
        tcnt_d   = tcnt_q;
        push_req = 1'b0;
        push_brk = 1'b0;
        push_ext = 1'b0;

        // A byte arriving on the timeout cycle is decoded in the old state.
        if (rx_listo) begin
            tcnt_d = '0;
            if (!is_junk) begin
                case (state_q)
                    IDLE: begin
                        if (is_e0)      state_d = GOT_E0;
                        else if (is_f0) state_d = GOT_F0;
                        else            push_req = 1'b1;
                    end
                    GOT_E0: begin
                        if (is_f0)       state_d = GOT_E0F0;
                        else if (!is_e0) begin push_req = 1'b1; push_ext = 1'b1; state_d = IDLE; end
                    end
                    GOT_F0: begin
                        if (is_e0)       state_d = GOT_E0;
                        else if (!is_f0) begin push_req = 1'b1; push_brk = 1'b1; state_d = IDLE; end
                    end
                    default: begin
                        if (!is_e0 && !is_f0) begin
                            push_req = 1'b1; push_brk = 1'b1; push_ext = 1'b1; state_d = IDLE;
                        end
                    end
                endcase
            end
        end else if (state_q == IDLE) begin
            tcnt_d = '0;
        end else if (tcnt_q == TMAX) begin
            tcnt_d  = '0;
            state_d = IDLE;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end

        push_ok  = push_req;
        held_v_d = held_v_q;
        held_d   = held_q;
`ifdef TYPEMATIC_FILTER_EN
        if (push_req) begin
            if (!push_brk) begin
                if (held_v_q && held_q == {push_ext, codigo_tecla}) push_ok = 1'b0;
                else begin held_v_d = 1'b1; held_d = {push_ext, codigo_tecla}; end
            end else if (held_v_q && held_q == {push_ext, codigo_tecla}) begin
                held_v_d = 1'b0;
            end
        end
`endif

        pop      = (count_q != '0) && evt_ready;
        wr_en    = push_ok && (!full_q || pop);
        ovf_d    = ovf_q | (push_ok && full_q && !pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {push_ext, push_brk, codigo_tecla};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(wr_en) - CW'(pop);
        full_d  = (count_d == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            held_v_q <= 1'b0;
            held_q   <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            held_v_q <= held_v_d;
            held_q   <= held_d;
        end
        mem_q <= mem_d;
    end

    assign head      = mem_q[rd_ptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_break = evt_valid & head[8];
    assign evt_ext   = evt_valid & head[9];
    assign fifo_full = full_q;
    assign rx_enable = !full_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - randomized and directed checks of ps2_scan_decoder against a flag/queue model
module tb_ps2_scan_decoder;
    localparam int D = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_listo = 1'b0;
    logic [7:0] codigo_tecla = 8'h00;
    logic       evt_ready = 1'b0;
    logic       rx_enable, evt_valid, evt_break, evt_ext, fifo_full, overflow;
    logic [7:0] evt_code;

    ps2_scan_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_listo(rx_listo), .codigo_tecla(codigo_tecla),
        .rx_enable(rx_enable), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending prefix flags, idle counter, event queue {ext,brk,code}
    logic [9:0] mq[$];
    logic [9:0] got[$];
    bit         m_ext = 0, m_brk = 0, m_ovf = 0, started = 0;
    int         m_tc = 0;
    bit         held_v = 0;
    logic [8:0] held = '0;

    function automatic bit is_junk(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hEE ||
               b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    always @(posedge clk) begin
        bit         have, pop;
        logic [9:0] ev;
        if (rst) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_tc = 0; m_ovf = 0; held_v = 0; started = 1;
        end else begin
            have = 0;
            ev   = '0;
            pop  = (mq.size() > 0) && evt_ready;
            if (rx_listo) begin
                m_tc = 0;
                if (is_junk(codigo_tecla)) begin
                end else if (codigo_tecla == 8'hE0) begin
                    if (!m_ext) m_brk = 0;
                    m_ext = 1;
                end else if (codigo_tecla == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    ev = {m_ext, m_brk, codigo_tecla};
                    have = 1;
                    m_ext = 0; m_brk = 0;
                end
            end else if (m_ext || m_brk) begin
                if (m_tc == T - 1) begin m_ext = 0; m_brk = 0; m_tc = 0; end
                else m_tc++;
            end else begin
                m_tc = 0;
            end
`ifdef TYPEMATIC_FILTER_EN
            if (have) begin
                if (!ev[8]) begin
                    if (held_v && held == {ev[9], ev[7:0]}) have = 0;
                    else begin held_v = 1; held = {ev[9], ev[7:0]}; end
                end else if (held_v && held == {ev[9], ev[7:0]}) held_v = 0;
            end
`endif
            if (pop) void'(mq.pop_front());
            if (have) begin
                if (mq.size() < D) mq.push_back(ev);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("evt_valid", evt_valid, mq.size() != 0);
            chk("fifo_full", fifo_full, mq.size() == D);
            chk("rx_enable", rx_enable, mq.size() != D);
            chk("overflow", overflow, m_ovf);
            if (mq.size() != 0) chk("head", {evt_ext, evt_break, evt_code}, mq[0]);
            if (!rst && evt_valid && evt_ready) got.push_back({evt_ext, evt_break, evt_code});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_listo = 1'b1;
        codigo_tecla = b;
        tick();
        rx_listo = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    logic [7:0] codes[5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [7:0] junks[7] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    logic [7:0] rnd_codes[5] = '{8'h1C, 8'h1D, 8'h75, 8'h15, 8'h24};

    initial begin
        int waited;
        int exp_n;
        do_reset();
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_code", evt_code, 8'h00);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_rxen", rx_enable, 1'b1);

        // Make and break with one-cycle latency
        evt_ready = 1'b1;
        send_byte(8'h1C);
        chk("lat_make", evt_valid, 1'b1);
        tick();
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("lat_break", evt_valid, 1'b1);
        settle(3);
        chk("n_basic", got.size(), 2);
        if (got.size() == 2) begin
            chk("ev_1c_make", got[0], {2'b00, 8'h1C});
            chk("ev_1c_break", got[1], {2'b01, 8'h1C});
        end

        got.delete();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        settle(3);
        chk("n_ext", got.size(), 2);
        if (got.size() == 2) begin
            chk("ev_75_make", got[0], {2'b10, 8'h75});
            chk("ev_75_break", got[1], {2'b11, 8'h75});
        end

        got.delete();
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hEE);
        settle(3);
        chk("n_junk", got.size(), 0);
        send_byte(8'h1C);
        settle(2);
        chk("junk_idle", got.size() > 0 ? got[0] : 10'h3FF, {2'b00, 8'h1C});

        got.delete();
        send_byte(8'hE0);
        settle(T);
        send_byte(8'h1C);
        settle(2);
        chk("n_timeout", got.size(), 1);
        chk("ev_timeout", got.size() > 0 ? got[0] : 10'h3FF, {2'b00, 8'h1C});

        // Fill, overflow, drain
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(codes[i]);
        chk("full4", fifo_full, 1'b1);
        chk("rxen4", rx_enable, 1'b0);
        chk("noovf4", overflow, 1'b0);
        send_byte(codes[4]);
        chk("ovf5", overflow, 1'b1);
        evt_ready = 1'b1;
        waited = 0;
        while (got.size() < 4 && waited < 20) begin tick(); waited++; end
        chk("drain_timeout", waited < 20, 1'b1);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("drain_order", got[i], {2'b00, codes[i]});

        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(codes[i]);
        evt_ready = 1'b1;
        send_byte(8'h2C);
        evt_ready = 1'b0;
        chk("pushpop_ovf", overflow, 1'b0);
        chk("pushpop_full", fifo_full, 1'b1);

        // Typematic repeats
        do_reset();
        evt_ready = 1'b1;
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        settle(6);
`ifdef TYPEMATIC_FILTER_EN
        exp_n = 2;
`else
        exp_n = 4;
`endif
        chk("n_typematic", got.size(), exp_n);
        chk("typ_first", got.size() > 0 ? got[0] : 10'h3FF, {2'b00, 8'h1C});
        chk("typ_last", got.size() > 0 ? got[got.size() - 1] : 10'h3FF, {2'b01, 8'h1C});

        // Randomized traffic checked every cycle by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) begin
                rx_listo = 1'b0;
                settle(T + $urandom_range(0, 4) - 2);
            end
            evt_ready = ($urandom_range(0, 2) != 0) && (c % 400 < 300);
            rx_listo  = ($urandom_range(0, 3) == 0) && (rx_enable || $urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            if (r < 2)       codigo_tecla = 8'hE0;
            else if (r < 4)  codigo_tecla = 8'hF0;
            else if (r == 4) codigo_tecla = junks[$urandom_range(0, 6)];
            else if (r == 5) codigo_tecla = 8'($urandom);
            else             codigo_tecla = rnd_codes[$urandom_range(0, 4)];
            tick();
        end
        rx_listo = 1'b0;
        settle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
